// File: rtl/bank_port_ctrl.sv
// Byte-wide bank port controller: turns 8/16-bit CPU loads and stores into one or two
// sequential accesses on an 8-bit, one-cycle-latency RAM port (little-endian).
module bank_port_ctrl (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [9:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        wea,
  output logic [9:0]  addra,
  output logic [7:0]  dina,
  input  logic [7:0]  douta
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    ISSUE_HI = 3'd2,
    CAPTURE  = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t      state_q;
  logic        write_q;
  logic        wide_q;
  logic [9:0]  addr_q;
  logic [7:0]  wdata_hi_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [15:0] rdata_q;
  logic        wea_q;
  logic [9:0]  addra_q;
  logic [7:0]  dina_q;
  logic [9:0]  addr_hi_d;

  // 10-bit add wraps 0x3FF to 0x000 for the high byte of a word.
  assign addr_hi_d = addr_q + 10'd1;

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      wide_q       <= 1'b0;
      addr_q       <= '0;
      wdata_hi_q   <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            wide_q     <= req_wide;
            addr_q     <= req_addr;
            wdata_hi_q <= req_wdata[15:8];
            wea_q      <= req_write;
            addra_q    <= req_addr;
            dina_q     <= req_wdata[7:0];
            ready_q    <= 1'b0;
            state_q    <= ISSUE_LO;
          end
        end
        ISSUE_LO: begin
          if (wide_q) begin
            wea_q   <= write_q;
            addra_q <= addr_hi_d;
            dina_q  <= wdata_hi_q;
            state_q <= ISSUE_HI;
          end else begin
            wea_q <= 1'b0;
            if (write_q) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        ISSUE_HI: begin
          wea_q <= 1'b0;
          if (write_q) begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            // Low byte read issued in ISSUE_LO is on douta this cycle.
            rdata_q[7:0] <= douta;
            state_q      <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (wide_q) begin
            rdata_q[15:8] <= douta;
          end else begin
            rdata_q <= {8'h00, douta};
          end
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          wea_q        <= 1'b0;
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Reset gates the write strobe so an aborted word store never commits its high byte.
  assign wea        = wea_q & rst_n;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

endmodule

// File: doc/bank_port_ctrl.md
BANK_PORT_CTRL -- requirements
Module: bank_port_ctrl

Interface
REQ-001 SHALL provide: clka, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n, input, 1, synchronous active-low reset sampled on the rising edge of clka.
REQ-003 SHALL provide: req_valid, input, 1, CPU access request.
REQ-004 SHALL provide: req_ready, output, 1, controller can accept a request this cycle.
REQ-005 SHALL provide: req_write, input, 1, 1 = store, 0 = load.
REQ-006 SHALL provide: req_wide, input, 1, 1 = 16-bit access, 0 = 8-bit access.
REQ-007 SHALL provide: req_addr, input, 10, byte address.
REQ-008 SHALL provide: req_wdata, input, 16, store data; low byte only used when req_wide = 0.
REQ-009 SHALL provide: resp_valid, output, 1, one-cycle completion pulse for load or store.
REQ-010 SHALL provide: resp_rdata, output, 16, load data, valid while resp_valid = 1.
REQ-011 SHALL provide: wea, output, 1, bank port-A write enable.
REQ-012 SHALL provide: addra, output, 10, bank port-A address.
REQ-013 SHALL provide: dina, output, 8, bank port-A write data.
REQ-014 SHALL provide: douta, input, 8, bank port-A read data, one-cycle registered read latency.

Function
REQ-015 SHALL implement states IDLE, ISSUE_LO, ISSUE_HI, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on edge E0 when req_valid = 1 and req_ready = 1, latching write, wide, addr and wdata; IDLE -> ISSUE_LO.
REQ-017 SHALL ignore req_valid, and all req_* inputs, outside IDLE.
REQ-018 SHALL register wea, addra and dina: in ISSUE_LO, addra = addr, dina = wdata[7:0], wea = write.
REQ-019 SHALL, in ISSUE_HI, drive addra = (addr + 1) mod 1024 (1023 wraps to 0), dina = wdata[15:8], wea = write.
REQ-020 SHALL hold wea = 0 in every state other than ISSUE_LO/ISSUE_HI; addra and dina hold their last values.
REQ-021 SHALL sequence transitions as:
- byte store: ISSUE_LO -> RESP
- word store: ISSUE_LO -> ISSUE_HI -> RESP
- byte load: ISSUE_LO -> CAPTURE -> RESP
- word load: ISSUE_LO -> ISSUE_HI -> CAPTURE -> RESP
- RESP -> IDLE always.
REQ-022 SHALL capture douta into resp_rdata[7:0] at the edge ending the cycle after ISSUE_LO, and into resp_rdata[15:8] at the edge ending the cycle after ISSUE_HI (little-endian).
REQ-023 SHALL set resp_rdata[15:8] = 0 for byte loads and hold resp_rdata unchanged for stores.
REQ-024 SHALL assert resp_valid exactly during RESP: cycle after E1 (byte store), E2 (word store, byte load), E3 (word load).
REQ-025 SHALL give a load issued immediately after a store to the same address the newly stored value, because the bank write completes before the read is issued.
REQ-026 SHALL permit back-to-back requests, with the next accept at the edge ending the cycle after RESP.

Reset
REQ-027 SHALL, while rst_n = 0 at a clock edge, force:
- state = IDLE
- wea = 0, addra = 0, dina = 0
- resp_valid = 0, resp_rdata = 0
- req_ready = 1 from the following cycle.
REQ-028 SHALL abort any in-flight transaction on reset without a resp_valid pulse; a word store aborted after ISSUE_LO leaves the high byte unwritten.

Verification
REQ-029 SHALL pass: byte store addr 0x005 data 0x3C, then byte load 0x005 -> resp_valid 2 cycles after load accept, resp_rdata = 0x003C.
REQ-030 SHALL pass: word store addr 0x3FF data 0xA55A -> writes 0x5A@0x3FF, 0xA5@0x000; word load 0x3FF -> resp_rdata = 0xA55A at E3.
REQ-031 SHALL pass: req_valid held high continuously with alternating store/load -> req_ready low from E0 through RESP; no request dropped or duplicated.
REQ-032 SHALL pass: rst_n low during ISSUE_HI of word store 0x1234 @0x010 -> no resp_valid, wea = 0 next cycle; 0x34 at 0x010, 0x011 unchanged.
REQ-033 SHALL pass: req_valid pulsed during CAPTURE of a load -> pulse ignored; only the original load responds.
REQ-034 SHALL pass: reset then idle 10 cycles -> wea = 0, resp_valid = 0, req_ready = 1 throughout.
